// File: rtl/rv32i_soc.sv
// rv32i_soc: minimal single-cycle RV32I system (core + instruction ROM).
// Ports (top): clk - system clock, rising edge; rst - async active-high reset.
// Sub-blocks: rv32i_rom (combinational instruction ROM), rv32i_regfile
// (32x32, 2R/1W), rv32i_core (fetch/decode/execute, pc register).

// Instruction ROM: one combinational read port, contents loaded externally.
// Ports: addr_i - word index; data_o - instruction word at that index.
module rv32i_rom #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   data_o
);
    logic [31:0] rom_mem [0:DEPTH-1];

    // Word index already wraps modulo DEPTH because it is only AW bits wide.
    assign data_o = rom_mem[addr_i];
endmodule

// Register file: x0..x31, two combinational reads, one clocked write.
// Ports: clk_i/rst_i; raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o;
// we_i, waddr_i, wdata_i - write port committed on the rising edge.
module rv32i_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);
    logic [31:0] regs [0:31];

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'h0 : regs[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'h0 : regs[raddr_b_i];
endmodule

// Single-cycle RV32I core (integer ALU, branches, jumps; other opcodes are NOPs).
// Ports: clk_i/rst_i; instr_i - fetched word; imem_addr_o - ROM word index.
module rv32i_core #(
    parameter int unsigned ROM_AW   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       instr_i,
    output logic [ROM_AW-1:0] imem_addr_o
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] alu_b, alu_res;
    logic        alu_alt;
    logic        br_taken;
    logic        rf_we;
    logic [31:0] rf_wd;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'h000};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    assign pc_plus4    = pc_q + 32'd4;
    assign imem_addr_o = pc_q[ROM_AW+1:2];

    rv32i_regfile regs_inst (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (rs1_data),
        .rdata_b_o (rs2_data),
        .we_i      (rf_we),
        .waddr_i   (rd),
        .wdata_i   (rf_wd)
    );

    // Bit 30 selects SUB/SRA; for OP-IMM it only matters for SRAI, since
    // ADDI's immediate may legitimately have bit 30 set.
    assign alu_b   = (opcode == OPC_OP) ? rs2_data : imm_i;
    assign alu_alt = instr_i[30] & ((opcode == OPC_OP) | (funct3 == 3'b101));

    // Shared ALU for OP and OP-IMM.
    always_comb begin
        alu_res = 32'h0;
        case (funct3)
            3'b000:  alu_res = alu_alt ? (rs1_data - alu_b) : (rs1_data + alu_b);
            3'b001:  alu_res = rs1_data << alu_b[4:0];
            3'b010:  alu_res = {31'h0, $signed(rs1_data) < $signed(alu_b)};
            3'b011:  alu_res = {31'h0, rs1_data < alu_b};
            3'b100:  alu_res = rs1_data ^ alu_b;
            3'b101:  alu_res = alu_alt ? 32'($signed(rs1_data) >>> alu_b[4:0])
                                       : (rs1_data >> alu_b[4:0]);
            3'b110:  alu_res = rs1_data | alu_b;
            default: alu_res = rs1_data & alu_b;
        endcase
    end

    // Branch condition; funct3 010/011 are reserved and never taken.
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_data == rs2_data);
            3'b001:  br_taken = (rs1_data != rs2_data);
            3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_taken = (rs1_data <  rs2_data);
            3'b111:  br_taken = (rs1_data >= rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    // Execute: register write-back and next pc; unknown opcodes fall through as NOP.
    always_comb begin
        rf_we = 1'b0;
        rf_wd = 32'h0;
        pc_d  = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                rf_we = 1'b1;
                rf_wd = imm_u;
            end
            OPC_AUIPC: begin
                rf_we = 1'b1;
                rf_wd = pc_q + imm_u;
            end
            OPC_JAL: begin
                rf_we = 1'b1;
                rf_wd = pc_plus4;
                pc_d  = pc_q + imm_j;
            end
            OPC_JALR: begin
                rf_we = 1'b1;
                rf_wd = pc_plus4;
                pc_d  = (rs1_data + imm_i) & ~32'h1;
            end
            OPC_BRANCH: begin
                if (br_taken) begin
                    pc_d = pc_q + imm_b;
                end
            end
            OPC_OPIMM, OPC_OP: begin
                rf_we = 1'b1;
                rf_wd = alu_res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// Top: core plus instruction ROM; only clock and reset leave the chip.
module rv32i_soc #(
    parameter int unsigned ROM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    localparam int unsigned ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    logic [ROM_AW-1:0] imem_addr;
    logic [31:0]       instr;

    rv32i_rom #(
        .DEPTH (ROM_DEPTH),
        .AW    (ROM_AW)
    ) rom_inst (
        .addr_i (imem_addr),
        .data_o (instr)
    );

    rv32i_core #(
        .ROM_AW   (ROM_AW),
        .RESET_PC (RESET_PC)
    ) riscv_inst (
        .clk_i       (clk),
        .rst_i       (rst),
        .instr_i     (instr),
        .imem_addr_o (imem_addr)
    );
endmodule

// File: tb/tb_rv32i_soc.sv
// Directed bench for rv32i_soc: small hand-assembled programs are written
// straight into the ROM, then registers and pc are checked by hierarchy.
module tb_rv32i_soc;
    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    logic [31:0] prog [$];

    rv32i_soc dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] xr(input int idx);
        return dut.riscv_inst.regs_inst.regs[idx];
    endfunction

    function automatic logic [31:0] pc();
        return dut.riscv_inst.pc_q;
    endfunction

    // Tiny assembler helpers.
    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return i_t(imm, rs1, 0, rd, 7'h13);
    endfunction

    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] b_t(input int f3, input int rs1, input int rs2, input int imm);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] jal(input int rd, input int imm);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic logic [31:0] u_t(input int imm20, input int rd, input logic [6:0] op);
        return {20'(imm20), 5'(rd), op};
    endfunction

    // Hold reset, fill ROM with NOPs plus the program, release on a falling edge.
    task automatic load_and_start();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = 32'h0000_0013;
        foreach (prog[i]) dut.rom_inst.rom_mem[i] = prog[i];
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit done;
        n_checks = 0;
        n_fail   = 0;

        // Reset takes effect without a clock edge.
        rst = 1'b1;
        #1;
        check("reset_pc", pc(), 32'h0);
        for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), xr(i), 32'h0);

        // ADDI and x0 discard.
        prog = {addi(1, 0, 5), addi(2, 1, -7), addi(0, 0, 9)};
        load_and_start();
        step(1);
        check("first_edge_pc", pc(), 32'd4);
        check("first_edge_x1", xr(1), 32'd5);
        step(2);
        check("addi_x1", xr(1), 32'd5);
        check("addi_x2", xr(2), 32'hFFFF_FFFE);
        check("addi_x0", xr(0), 32'h0);
        check("addi_pc", pc(), 32'd12);

        // Mid-run asynchronous reset, then re-execution from word 0.
        rst = 1'b1;
        #1;
        check("midrst_pc", pc(), 32'h0);
        check("midrst_x1", xr(1), 32'h0);
        check("midrst_x2", xr(2), 32'h0);
        step(2);
        check("midrst_hold_pc", pc(), 32'h0);
        check("midrst_hold_x1", xr(1), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(3);
        check("rerun_x1", xr(1), 32'd5);
        check("rerun_x2", xr(2), 32'hFFFF_FFFE);
        check("rerun_pc", pc(), 32'd12);

        // Branch and jump.
        prog = {addi(1, 0, 1), b_t(1, 1, 0, 8), addi(2, 0, 9), jal(3, 8),
                addi(4, 0, 1), addi(5, 0, 2)};
        load_and_start();
        step(4);
        check("br_x2", xr(2), 32'h0);
        check("br_x3", xr(3), 32'd16);
        check("br_x4", xr(4), 32'h0);
        check("br_x5", xr(5), 32'd2);
        check("br_pc", pc(), 32'd24);

        // ALU corners around 0x8000_0000.
        prog = {u_t(32'h80000, 1, 7'h37), i_t(32'h41F, 1, 5, 2, 7'h13),
                i_t(31, 1, 5, 3, 7'h13), r_t(0, 0, 1, 2, 4), r_t(0, 0, 1, 3, 5),
                r_t(32, 1, 0, 0, 6)};
        load_and_start();
        step(6);
        check("alu_lui", xr(1), 32'h8000_0000);
        check("alu_srai", xr(2), 32'hFFFF_FFFF);
        check("alu_srli", xr(3), 32'h1);
        check("alu_slt", xr(4), 32'h1);
        check("alu_sltu", xr(5), 32'h0);
        check("alu_sub", xr(6), 32'h8000_0000);

        // Self-checking program: x3 test number, x26 done, x27 pass.
        prog = {
            addi(3, 0, 1), addi(5, 0, -1), addi(6, 5, 1), b_t(1, 6, 0, 124),   // 0..3
            addi(3, 0, 2), b_t(4, 5, 0, 8), jal(0, 112),                        // 4..6
            addi(3, 0, 3), b_t(7, 5, 0, 8), jal(0, 100),                        // 7..9
            addi(3, 0, 4), u_t(1, 7, 7'h17), u_t(1, 8, 7'h37), addi(8, 8, 44),
            b_t(1, 7, 8, 80),                                                   // 10..14
            addi(3, 0, 5), addi(9, 0, 81), i_t(0, 9, 0, 10, 7'h67), jal(0, 64),
            jal(0, 60), addi(11, 0, 72), b_t(1, 10, 11, 52),                    // 15..21
            addi(3, 0, 6), i_t(0, 0, 2, 12, 7'h03), b_t(1, 12, 0, 40),          // 22..24
            addi(3, 0, 7), addi(13, 0, -16), addi(14, 0, 33), r_t(32, 14, 13, 5, 15),
            addi(16, 0, -8), b_t(1, 15, 16, 16),                                // 25..30
            addi(26, 0, 1), addi(27, 0, 1), jal(0, 0),                          // 31..33
            addi(26, 0, 1), jal(0, 0)                                           // 34..35 fail
        };
        load_and_start();
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            step(1);
            if (xr(26) == 32'd1) done = 1'b1;
        end
        check("cpl_done", 32'(done), 32'd1);
        step(2);
        check("cpl_pass", xr(27), 32'd1);
        check("cpl_testnum", xr(3), 32'd7);
        check("cpl_auipc", xr(7), 32'd4140);
        check("cpl_jalr_link", xr(10), 32'd72);
        check("cpl_load_nop", xr(12), 32'h0);
        check("cpl_sra", xr(15), 32'hFFFF_FFF8);
        check("cpl_pc", pc(), 32'd132);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_soc.md
Name: rv32i_soc

Overview:
Minimal RV32I system-on-chip: a single-cycle RV32I integer core fetching from an internal instruction ROM and executing register-to-register, immediate, upper-immediate, jump and branch instructions. It is the top of the simulation build, and its only ports are clock and reset. Compliance programs (rv32ui-p style) are preloaded into ROM by the bench. Pass/fail is read from architectural registers through fixed hierarchical paths.

Parameters:
ROM_DEPTH, 4096, instruction ROM size in 32-bit words
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset; state is cleared immediately on assertion

Behaviour:
- Hierarchy, fixed because benches probe it:
  - Core instance riscv_inst.
  - Register file instance riscv_inst.regs_inst, holding array regs[0:31] of 32-bit entries.
  - ROM instance rom_inst, holding array rom_mem[0:ROM_DEPTH-1] of 32-bit entries.
  - rom_mem is loadable by $readmemh with one hex word per line, starting at index 0.
- Reset (async, rst=1): pc=RESET_PC and regs[0..31]=0. ROM contents are untouched. Hold state while rst=1.
- Fetch: instruction = rom_mem[pc[31:2] mod ROM_DEPTH]. This is a combinational read. pc[1:0] is ignored.
- Timing:
  - Single-cycle: each rising edge with rst=0 retires exactly one instruction.
  - The register write and the pc update commit on the same edge.
  - The first edge after reset release executes the word at RESET_PC.
- Register file:
  - Two combinational read ports and one write port on the clock edge.
  - Writes to x0 are discarded; x0 always reads 0.
  - A read in the same cycle as a write to the same register returns the old value; single-cycle operation makes this harmless.
- Supported instructions:
  - LUI, AUIPC.
  - JAL, JALR: rd=pc+4; JALR target=(rs1+imm)&~1.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic rules:
  - All arithmetic is 32-bit modulo 2^32; overflow wraps with no trap.
  - I/S/B/U/J immediates are sign-extended per the RV32I encoding.
  - Shift amount = low 5 bits of rs2 or of the immediate.
  - SLT/BLT/BGE compare signed; SLTU/SLTIU/BLTU/BGEU compare unsigned.
- Next PC:
  - Taken branch or jump: pc+imm (JALR as above).
  - Otherwise: pc+4.
  - Misaligned targets are not trapped; the low bits are dropped at fetch.
- Unsupported or other opcodes (loads, stores, FENCE, ECALL, EBREAK, CSR, illegal encodings) execute as NOP: no register write, pc+4.
- No interrupts, no exceptions, no data memory.
- Reset asserted mid-program: the architectural state is cleared asynchronously and execution restarts from RESET_PC after release.
- Test convention, to be supported as ordinary register writes:
  - x3 holds the current test number.
  - x26 is set to 1 when the test is done.
  - x27 is set to 1 for pass, 0 for fail.

Test Plan:
- Reset: assert rst with random regs and pc -> pc=0, all regs=0 immediately, without waiting for a clock edge.
- ADDI/x0: ROM = {addi x1,x0,5; addi x2,x1,-7; addi x0,x0,9} -> after 3 edges x1=5, x2=32'hFFFF_FFFE, x0=0.
- Branch/jump:
  - ROM = {addi x1,x0,1; bne x1,x0,+8; addi x2,x0,9; jal x3,+8; addi x4,x0,1; addi x5,x0,2}.
  - Expected x2=0 (skipped), x3=16, x4=0, x5=2.
- ALU corners:
  - lui x1,0x80000; srai x2,x1,31; srli x3,x1,31; slt x4,x1,x0; sltu x5,x1,x0; sub x6,x0,x1.
  - Expected x2=FFFF_FFFF, x3=1, x4=1, x5=0, x6=8000_0000.
- Compliance: load the rv32ui-p-addi hex image and run until x26=1 -> x27=1 within 1000 cycles; on failure, x3 reports the failing test number.
- Mid-run reset: assert rst asynchronously while x1≠0 -> regs clear and pc=0 at once; after release, the program re-executes from word 0 with identical results.
